// File: rtl/hall_pkg.sv
// Shared types and helpers for the hall-sensor sector decoder.
package hall_pkg;

  typedef logic [2:0] sector_t;

  localparam int         SECTOR_COUNT = 6;
  localparam logic [2:0] HALL_INV_LO  = 3'b000;
  localparam logic [2:0] HALL_INV_HI  = 3'b111;

  typedef struct packed {
    logic    valid;
    sector_t sector;
  } hall_dec_t;

  // Map a {C,B,A} hall code onto its commutation sector; 000/111 are invalid.
  function automatic hall_dec_t hall_to_sector(input logic [2:0] code);
    hall_dec_t d;
    d.valid  = 1'b1;
    d.sector = 3'd0;
    case (code)
      3'b001:  d.sector = 3'd0;
      3'b011:  d.sector = 3'd1;
      3'b010:  d.sector = 3'd2;
      3'b110:  d.sector = 3'd3;
      3'b100:  d.sector = 3'd4;
      3'b101:  d.sector = 3'd5;
      default: d.valid  = 1'b0;
    endcase
    return d;
  endfunction

  function automatic sector_t sector_next(input sector_t s);
    return (s == sector_t'(SECTOR_COUNT - 1)) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic sector_t sector_prev(input sector_t s);
    return (s == 3'd0) ? sector_t'(SECTOR_COUNT - 1) : s - 3'd1;
  endfunction

endpackage

// File: rtl/hall_glitch_filter.sv
// Two-flop synchronizer plus stability filter for the raw hall inputs.
// o_accept is a combinational strobe that is high on the edge where
// o_filt_hall takes a new value; o_accept_code is the value being taken.
module hall_glitch_filter
  import hall_pkg::*;
#(
  parameter int FILTER_LEN = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_hall,
  output logic [2:0] o_filt_hall,
  output logic       o_accept,
  output logic [2:0] o_accept_code
);

  localparam int               CNT_W   = $clog2(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [2:0]       r_s1;
  logic [2:0]       r_s2;
  logic [2:0]       r_cand;
  logic [2:0]       r_filt;
  logic [CNT_W-1:0] r_fcnt;
  logic             r_primed;
  logic             w_stable;

  // The very first stable code after reset is always reported, even if it
  // matches the reset value of r_filt, so downstream sees an initial state.
  assign w_stable      = (r_s2 == r_cand) && (r_fcnt == CNT_MAX);
  assign o_accept      = w_stable && (!r_primed || (r_cand != r_filt));
  assign o_accept_code = r_cand;
  assign o_filt_hall   = r_filt;

  // Synchronize, then require the candidate to hold for FILTER_LEN cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1     <= 3'b000;
      r_s2     <= 3'b000;
      r_cand   <= 3'b000;
      r_filt   <= 3'b000;
      r_fcnt   <= '0;
      r_primed <= 1'b0;
    end else begin
      r_s1 <= i_hall;
      r_s2 <= r_s1;
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_fcnt <= '0;
      end else if (r_fcnt == CNT_MAX) begin
        r_filt   <= r_cand;
        r_primed <= 1'b1;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hall_sector_decoder.sv
// Hall sensor conditioning: filtered code -> sector, direction, step strobe,
// step period measurement, and skip/fault/stall reporting.
module hall_sector_decoder
  import hall_pkg::*;
#(
  parameter int FILTER_LEN   = 16,
  parameter int PERIOD_W     = 24,
  parameter int STALL_CYCLES = 2700000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          hall_in,
  output logic [2:0]          filt_hall,
  output logic [2:0]          sector,
  output logic                sector_valid,
  output logic                step_pulse,
  output logic                dir,
  output logic                skip_err,
  output logic                hall_fault,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stall
);

  localparam logic [PERIOD_W-1:0] PCNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] STALL_TC = PERIOD_W'(STALL_CYCLES - 1);

  logic [2:0]          w_filt_hall;
  logic                w_accept;
  logic [2:0]          w_accept_code;
  hall_dec_t           w_dec;
  logic                w_fwd;
  logic                w_rev;
  logic                w_step;
  logic                w_skip;
  logic [PERIOD_W-1:0] w_period_next;

  sector_t             r_sector;
  logic                r_sector_valid;
  logic                r_step;
  logic                r_dir;
  logic                r_skip;
  logic                r_fault;
  logic [PERIOD_W-1:0] r_period;
  logic                r_period_valid;
  logic                r_stall;
  logic [PERIOD_W-1:0] r_pcnt;
  // Previous step was legal with nothing (fault/skip/stall) since.
  logic                r_chain;

  hall_glitch_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_hall       (hall_in),
    .o_filt_hall  (w_filt_hall),
    .o_accept     (w_accept),
    .o_accept_code(w_accept_code)
  );

  // Classify the code being accepted this cycle against the current sector.
  always_comb begin
    w_dec         = hall_to_sector(w_accept_code);
    w_fwd         = (w_dec.sector == sector_next(r_sector));
    w_rev         = (w_dec.sector == sector_prev(r_sector));
    w_step        = w_accept && w_dec.valid && r_sector_valid && (w_fwd || w_rev);
    w_skip        = w_accept && w_dec.valid && r_sector_valid && !(w_fwd || w_rev);
    w_period_next = (r_pcnt == PCNT_MAX) ? PCNT_MAX : r_pcnt + 1'b1;
  end

  // Sector tracking, strobes, period measurement and stall detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sector       <= 3'd0;
      r_sector_valid <= 1'b0;
      r_step         <= 1'b0;
      r_dir          <= 1'b1;
      r_skip         <= 1'b0;
      r_fault        <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_stall        <= 1'b0;
      r_pcnt         <= '0;
      r_chain        <= 1'b0;
    end else begin
      r_step <= w_step;
      r_skip <= w_skip;

      if (w_step)                 r_pcnt <= '0;
      else if (r_pcnt != PCNT_MAX) r_pcnt <= r_pcnt + 1'b1;

      if (w_accept) begin
        if (!w_dec.valid) begin
          r_fault        <= 1'b1;
          r_sector_valid <= 1'b0;
          r_period_valid <= 1'b0;
          r_chain        <= 1'b0;
        end else begin
          r_sector       <= w_dec.sector;
          r_sector_valid <= 1'b1;
          r_fault        <= 1'b0;
          if (w_step) begin
            r_dir          <= w_fwd;
            r_period       <= w_period_next;
            r_period_valid <= r_chain && (w_fwd == r_dir) && !r_stall;
            r_chain        <= 1'b1;
            r_stall        <= 1'b0;
          end else if (w_skip) begin
            r_period_valid <= 1'b0;
            r_chain        <= 1'b0;
          end
        end
      end

      // A step on this edge restarts the count, so it wins over the threshold.
      if (!w_step && (r_pcnt == STALL_TC)) begin
        r_stall        <= 1'b1;
        r_period_valid <= 1'b0;
        r_chain        <= 1'b0;
      end
    end
  end

  assign filt_hall    = w_filt_hall;
  assign sector       = r_sector;
  assign sector_valid = r_sector_valid;
  assign step_pulse   = r_step;
  assign dir          = r_dir;
  assign skip_err     = r_skip;
  assign hall_fault   = r_fault;
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign stall        = r_stall;

endmodule

// File: tb/tb_hall_sector_decoder.sv
// Self-checking bench: directed scenarios plus random hall sequences, all
// compared each cycle against a behavioural model of the decoder.
module tb_hall_sector_decoder;

  localparam int FL  = 4;
  localparam int PW  = 24;
  localparam int SC  = 1000;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    hall_in = 3'b000;
  logic [2:0]    filt_hall;
  logic [2:0]    sector;
  logic          sector_valid;
  logic          step_pulse;
  logic          dir;
  logic          skip_err;
  logic          hall_fault;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          stall;

  int n_cmp = 0;
  int n_err = 0;

  hall_sector_decoder #(
    .FILTER_LEN  (FL),
    .PERIOD_W    (PW),
    .STALL_CYCLES(SC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hall_in     (hall_in),
    .filt_hall   (filt_hall),
    .sector      (sector),
    .sector_valid(sector_valid),
    .step_pulse  (step_pulse),
    .dir         (dir),
    .skip_err    (skip_err),
    .hall_fault  (hall_fault),
    .period      (period),
    .period_valid(period_valid),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  // code -> sector (-1 invalid), and sector -> code
  int         sec_of[8]  = '{-1, 0, 2, 1, 4, 5, 3, -1};
  logic [2:0] code_of[6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  // ---------------- behavioural model ----------------
  int         cyc = 0;
  logic [2:0] hist[$];
  bit         m_init = 0;
  bit         m_primed, m_sv, m_step, m_dir, m_skip, m_fault, m_pv, m_stall, m_chain;
  logic [2:0] m_filt;
  int         m_sector, m_period, last_step;

  always @(posedge clk) begin
    bit         acc, ok, stepped, nd;
    logic [2:0] v;
    int         n, d, since;
    cyc++;
    if (rst) begin
      m_init = 1; m_primed = 0; m_filt = 3'b000; m_sector = 0; m_sv = 0;
      m_step = 0; m_dir = 1; m_skip = 0; m_fault = 0; m_period = 0;
      m_pv = 0; m_stall = 0; m_chain = 0; last_step = cyc;
      hist.delete();
      repeat (3) hist.push_back(3'b000);
    end else begin
      // accepted when the FL+1 synchronized samples ending two edges ago agree
      acc = 0; v = 3'b000;
      if (hist.size() >= FL + 2) begin
        v  = hist[hist.size() - 2];
        ok = 1;
        for (int i = 2; i <= FL + 2; i++)
          if (hist[hist.size() - i] != v) ok = 0;
        acc = ok && (!m_primed || v != m_filt);
      end
      hist.push_back(hall_in);
      if (hist.size() > FL + 3) void'(hist.pop_front());

      m_step = 0; m_skip = 0; stepped = 0;
      since = cyc - last_step;
      if (acc) begin
        m_filt = v; m_primed = 1;
        n = sec_of[v];
        if (n < 0) begin
          m_fault = 1; m_sv = 0; m_pv = 0; m_chain = 0;
        end else if (!m_sv) begin
          m_sector = n; m_sv = 1; m_fault = 0;
        end else begin
          d = (n - m_sector + 6) % 6;
          m_sector = n; m_fault = 0;
          if (d == 1 || d == 5) begin
            nd = (d == 1);
            m_step = 1; stepped = 1;
            m_pv = m_chain && (nd == m_dir) && !m_stall;
            m_dir = nd;
            m_period = (since > PMAX) ? PMAX : since;
            m_chain = 1; m_stall = 0;
          end else begin
            m_skip = 1; m_pv = 0; m_chain = 0;
          end
        end
      end
      if (stepped) last_step = cyc;
      else if (since == SC) begin
        m_stall = 1; m_pv = 0; m_chain = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (m_init) begin
      chk("filt_hall",    32'(filt_hall),    32'(m_filt));
      chk("sector",       32'(sector),       32'(m_sector));
      chk("sector_valid", 32'(sector_valid), 32'(m_sv));
      chk("step_pulse",   32'(step_pulse),   32'(m_step));
      chk("dir",          32'(dir),          32'(m_dir));
      chk("skip_err",     32'(skip_err),     32'(m_skip));
      chk("hall_fault",   32'(hall_fault),   32'(m_fault));
      chk("period",       32'(period),       32'(m_period));
      chk("period_valid", 32'(period_valid), 32'(m_pv));
      chk("stall",        32'(stall),        32'(m_stall));
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [2:0] c, input int n);
    @(negedge clk);
    hall_in = c;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cur, r, len, nxt;
    repeat (5) @(negedge clk);
    // 1: first valid code after reset
    rst = 1'b0;
    hall_in = 3'b001;
    repeat (6) @(posedge clk);
    #2 chk("lit_filt_edge6", 32'(filt_hall), 32'd0);
    @(posedge clk);
    #2;
    chk("lit_filt_edge7", 32'(filt_hall), 32'd1);
    chk("lit_sv_edge7",   32'(sector_valid), 32'd1);
    chk("lit_sec_edge7",  32'(sector), 32'd0);
    chk("lit_step_edge7", 32'(step_pulse), 32'd0);
    chk("lit_fault_edge7", 32'(hall_fault), 32'd0);
    hold(3'b001, 93);
    // 2: forward steps
    hold(3'b011, 100);
    hold(3'b010, 100);
    hold(3'b110, 100);
    chk("lit_fwd_sector", 32'(sector), 32'd3);
    chk("lit_fwd_dir",    32'(dir), 32'd1);
    chk("lit_fwd_period", 32'(period), 32'd100);
    chk("lit_fwd_pv",     32'(period_valid), 32'd1);
    // 3: reversal
    hold(3'b010, 100);
    chk("lit_rev_dir", 32'(dir), 32'd0);
    chk("lit_rev_sec", 32'(sector), 32'd2);
    chk("lit_rev_pv",  32'(period_valid), 32'd0);
    hold(3'b011, 100);
    chk("lit_rev2_pv",  32'(period_valid), 32'd1);
    chk("lit_rev2_sec", 32'(sector), 32'd1);
    // 4: short glitch is rejected
    hold(3'b111, 3);
    hold(3'b011, 50);
    chk("lit_glitch_filt", 32'(filt_hall), 32'd3);
    chk("lit_glitch_sec",  32'(sector), 32'd1);
    // 5: invalid code, then resync
    hold(3'b111, 50);
    chk("lit_fault",     32'(hall_fault), 32'd1);
    chk("lit_fault_sv",  32'(sector_valid), 32'd0);
    chk("lit_fault_sec", 32'(sector), 32'd1);
    hold(3'b100, 50);
    chk("lit_resync_sec",   32'(sector), 32'd4);
    chk("lit_resync_sv",    32'(sector_valid), 32'd1);
    chk("lit_resync_fault", 32'(hall_fault), 32'd0);
    // 6: skip, stall, recovery
    hold(3'b101, 100);
    hold(3'b001, 100);
    @(negedge clk);
    hall_in = 3'b010;
    repeat (7) @(posedge clk);
    #2;
    chk("lit_skip",      32'(skip_err), 32'd1);
    chk("lit_skip_step", 32'(step_pulse), 32'd0);
    chk("lit_skip_pv",   32'(period_valid), 32'd0);
    hold(3'b010, 1100);
    chk("lit_stall", 32'(stall), 32'd1);
    hold(3'b110, 100);
    chk("lit_stall_clr",    32'(stall), 32'd0);
    chk("lit_stall_clr_pv", 32'(period_valid), 32'd0);

    // random phase
    cur = 3;
    for (int k = 0; k < 250; k++) begin
      r   = $urandom_range(0, 99);
      len = ($urandom_range(0, 99) < 4) ? 1100 : $urandom_range(1, 150);
      if (r < 3) begin
        do_reset($urandom_range(1, 3));
        hold(3'b000, $urandom_range(1, 20));
      end else if (r < 43) begin
        cur = (cur + 1) % 6; hold(code_of[cur], len);
      end else if (r < 63) begin
        cur = (cur + 5) % 6; hold(code_of[cur], len);
      end else if (r < 73) begin
        cur = (cur + $urandom_range(2, 4)) % 6; hold(code_of[cur], len);
      end else if (r < 81) begin
        hold(($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000, $urandom_range(1, 60));
        hold(code_of[cur], len);
      end else if (r < 93) begin
        nxt = $urandom_range(0, 7);
        hold(3'(nxt), $urandom_range(1, FL - 1));
        hold(code_of[cur], len);
      end else begin
        cur = $urandom_range(0, 5); hold(code_of[cur], len);
      end
    end
    hold(code_of[cur], 20);
    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
